inst_queue: RTL and testbench
=============================

# inst_queue

Instruction queue between the fetch stage and decode. It captures each fetched (pc, instruction) pair into a small FIFO and presents the oldest entry to decode with a valid/ready handshake. It drives the fetch stage's stop input while full, and discards all contents on a control-flow redirect. This decouples decode stalls from fetch and absorbs short decode back-pressure.

## Interface
- DEPTH, 4, number of entries; power of two, >= 2
- NOP_INST, 32'h00000013, instruction value presented on out_inst while empty (addi x0,x0,0)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  redirect (jump/branch taken); discards every entry
- in_valid  in  1  fetch presents a valid pc/instruction this cycle
- in_pc  in  32  pc of the presented instruction
- in_inst  in  32  instruction word at in_pc
- in_stop  out  1  queue full; wired to the fetch stage's stop input (fetch holds pc)
- out_valid  out  1  out_pc/out_inst hold a valid entry
- out_pc  out  32  pc of oldest entry
- out_inst  out  32  instruction of oldest entry
- out_ready  in  1  decode accepts the presented entry this cycle
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH entries of {pc[31:0], inst[31:0]}; write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH; count tracks occupancy separately.
- push = in_valid & ~in_stop & ~flush. On push: entry[wr_ptr] <= {in_pc, in_inst}, wr_ptr increments.
- pop = out_valid & out_ready & ~flush. On pop: rd_ptr increments.
- count next = count + push - pop; push and pop in the same cycle leave count unchanged.
- in_stop = (count == DEPTH), decoded from registered count only; no combinational path from out_ready or in_valid.
- When full, the fetch stage holds its pc and keeps presenting the same instruction; it is accepted on the first cycle after count drops below DEPTH. No double capture is possible because push requires ~in_stop.
- A push while full is rejected even if a pop occurs that cycle (no full bypass).
- out_valid = (count != 0). No empty bypass: an instruction pushed into an empty queue is not visible until the next cycle.
- While out_valid = 0: out_pc = 32'h0, out_inst = NOP_INST. While out_valid = 1: out_pc/out_inst = entry[rd_ptr].
- Flush: next cycle count = 0, wr_ptr = rd_ptr = 0; any push or pop in the flush cycle is discarded. Entry storage is not cleared.
- Reset: count = 0, pointers = 0, so out_valid = 0, out_pc = 0, out_inst = NOP_INST, in_stop = 0. Entry storage needs no reset. Reset asserted mid-operation discards all contents immediately (asynchronous).
- pc values, including the post-reset fetch pc 32'hFFFFFFFC, are stored verbatim; the queue never interprets pc or instruction bits.

## Timing
- Push-to-output latency: 1 cycle. An entry written at edge N is on out_* after edge N, while empty before.
- Pop: the next entry appears on out_* after the accepting edge. Sustained throughput is 1 push and 1 pop per cycle.
- in_stop rises the cycle after the edge that makes count = DEPTH. It falls the cycle after the first pop from full.
- Flush: out_valid is 0 and in_stop is 0 in the cycle after the flush edge. The first post-redirect instruction can be pushed in that same cycle.
- All outputs are registered-state derived; out_ready affects only next-state.

## Test plan
- Reset, then push pc 0x0/0x4/0x8 with inst 0xA0,0xA1,0xA2 and out_ready=0 -> count=3, out_pc=0x0, out_inst=0xA0; then out_ready=1 -> pops in order 0x0,0x4,0x8 over three cycles, then out_valid=0, out_inst=0x00000013.
- Continuous in_valid, out_ready=0 -> count saturates at 4, in_stop=1; the held instruction (pc 0xC) is captured exactly once after a single pop, and count returns to 4.
- Full queue with in_valid and out_ready=1 in the same cycle -> pop accepted, push rejected, count=3; next cycle push accepted, count=4.
- Queue holding 3 entries, flush=1 together with in_valid (pc 0x40) and out_ready=1 -> next cycle count=0, out_valid=0, pc 0x40 not stored; pc 0x80 pushed in the following cycle appears one cycle later.
- 10 pushes/pops at 1 per cycle (pointer wrap past DEPTH) -> output pc sequence matches input order with no loss or duplication; count stays at 1.
- rst_n pulled low asynchronously mid-stream with 2 entries present -> out_valid=0, in_stop=0, count=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/inst_queue_if.sv
// rtl/inst_queue_if.sv - fetch/decode handshake bundle for the instruction queue
interface inst_queue_if #(
    parameter int DEPTH = 4
);
    logic                     flush;
    logic                     in_valid;
    logic [31:0]              in_pc;
    logic [31:0]              in_inst;
    logic                     in_stop;
    logic                     out_valid;
    logic [31:0]              out_pc;
    logic [31:0]              out_inst;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   count;

    // slave is the queue itself; master is the surrounding fetch/decode side
    modport slave (
        input  flush, in_valid, in_pc, in_inst, out_ready,
        output in_stop, out_valid, out_pc, out_inst, count
    );

    modport master (
        output flush, in_valid, in_pc, in_inst, out_ready,
        input  in_stop, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - fetch-to-decode instruction FIFO with full stop and redirect flush
module inst_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst_n,
    inst_queue_if.slave   q
);
    localparam int             PW   = $clog2(DEPTH);
    localparam int             CW   = PW + 1;
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // full/empty come from registered count only, so no in->out combinational path
    assign full  = (count == FULL);
    assign empty = (count == '0);
    assign push  = q.in_valid & ~full & ~q.flush;
    assign pop   = ~empty & q.out_ready & ~q.flush;

    // storage is deliberately left unreset; out_valid masks stale contents
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= q.in_pc;
            inst_mem[wr_ptr] <= q.in_inst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (q.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign q.in_stop   = full;
    assign q.out_valid = ~empty;
    assign q.out_pc    = empty ? 32'h0    : pc_mem[rd_ptr];
    assign q.out_inst  = empty ? NOP_INST : inst_mem[rd_ptr];
    assign q.count     = count;
endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - scoreboard bench for inst_queue
module tb_inst_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   mcount;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t exp_q[$];

    inst_queue_if #(.DEPTH(DEPTH)) q();

    inst_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (q.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: any handshake that will complete at the next edge must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && !q.flush && q.out_valid && q.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", q.out_pc, 32'hDEAD_BEEF);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                check("pop_pc", q.out_pc, e.pc);
                check("pop_inst", q.out_inst, e.inst);
            end
        end
    end

    // Drive one cycle; called at posedge+1, returns at the following posedge+1
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic rdy, input logic fl, output logic acc);
        logic pp;
        q.in_valid  = v;
        q.in_pc     = pc;
        q.in_inst   = inst;
        q.out_ready = rdy;
        q.flush     = fl;
        acc = v && (mcount != DEPTH) && !fl;
        pp  = (mcount != 0) && rdy && !fl;
        if (fl) exp_q.delete();
        if (acc) exp_q.push_back({pc, inst});
        @(posedge clk);
        #1;
        if (fl) mcount = 0;
        else    mcount = mcount + int'(acc) - int'(pp);
    endtask

    initial begin
        logic        acc;
        logic [31:0] fpc;
        checks   = 0;
        failures = 0;
        mcount   = 0;
        rst_n       = 1'b0;
        q.flush     = 1'b0;
        q.in_valid  = 1'b0;
        q.in_pc     = '0;
        q.in_inst   = '0;
        q.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_count", 32'(q.count), 32'd0);
        check("rst_out_valid", 32'(q.out_valid), 32'd0);
        check("rst_out_pc", q.out_pc, 32'h0);
        check("rst_out_inst", q.out_inst, NOP);
        check("rst_in_stop", 32'(q.in_stop), 32'd0);

        // Three pushes with decode stalled, then drain in order
        step(1, 32'h0, 32'hA0, 0, 0, acc);
        check("t1_visible_after_1", q.out_pc, 32'h0);
        step(1, 32'h4, 32'hA1, 0, 0, acc);
        step(1, 32'h8, 32'hA2, 0, 0, acc);
        check("t1_count", 32'(q.count), 32'd3);
        check("t1_out_pc", q.out_pc, 32'h0);
        check("t1_out_inst", q.out_inst, 32'hA0);
        repeat (3) step(0, 32'h0, 32'h0, 1, 0, acc);
        check("t1_empty_valid", 32'(q.out_valid), 32'd0);
        check("t1_empty_inst", q.out_inst, NOP);
        check("t1_empty_pc", q.out_pc, 32'h0);

        // Fill to full starting from the post-reset fetch pc; fetch holds pc while stopped
        fpc = 32'hFFFF_FFFC;
        repeat (6) begin
            step(1, fpc, fpc ^ 32'h5A5A_0000, 0, 0, acc);
            if (acc) fpc = fpc + 32'd4;
        end
        check("t2_count_full", 32'(q.count), 32'd4);
        check("t2_in_stop", 32'(q.in_stop), 32'd1);
        check("t2_held_pc", fpc, 32'hC);
        check("t2_head_pc", q.out_pc, 32'hFFFF_FFFC);
        step(1, fpc, fpc ^ 32'h5A5A_0000, 1, 0, acc);
        check("t3_no_full_bypass", 32'(q.count), 32'd3);
        check("t3_stop_low", 32'(q.in_stop), 32'd0);
        if (acc) fpc = fpc + 32'd4;
        step(1, fpc, fpc ^ 32'h5A5A_0000, 0, 0, acc);
        check("t3_refill", 32'(q.count), 32'd4);
        check("t3_stop_high", 32'(q.in_stop), 32'd1);
        repeat (4) step(0, 32'h0, 32'h0, 1, 0, acc);
        check("t3_drained", 32'(q.count), 32'd0);

        // Flush with simultaneous push and pop discards everything
        step(1, 32'h20, 32'hB0, 0, 0, acc);
        step(1, 32'h24, 32'hB1, 0, 0, acc);
        step(1, 32'h28, 32'hB2, 0, 0, acc);
        step(1, 32'h40, 32'hB3, 1, 1, acc);
        check("t4_count", 32'(q.count), 32'd0);
        check("t4_valid", 32'(q.out_valid), 32'd0);
        check("t4_stop", 32'(q.in_stop), 32'd0);
        check("t4_inst", q.out_inst, NOP);
        step(1, 32'h80, 32'hB4, 0, 0, acc);
        check("t4_post_valid", 32'(q.out_valid), 32'd1);
        check("t4_post_pc", q.out_pc, 32'h80);
        check("t4_post_count", 32'(q.count), 32'd1);
        step(0, 32'h0, 32'h0, 1, 0, acc);

        // Streaming one push and one pop per cycle across pointer wrap
        step(1, 32'h200, 32'hC00, 1, 0, acc);
        for (int i = 1; i <= 10; i++) begin
            step(1, 32'h200 + 32'(i * 4), 32'hC00 + 32'(i), 1, 0, acc);
            check("t5_count_steady", 32'(q.count), 32'd1);
        end
        step(0, 32'h0, 32'h0, 1, 0, acc);
        check("t5_drained", 32'(q.count), 32'd0);

        // Asynchronous reset mid-stream
        step(1, 32'h300, 32'hD0, 0, 0, acc);
        step(1, 32'h304, 32'hD1, 0, 0, acc);
        check("t6_pre_count", 32'(q.count), 32'd2);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        mcount = 0;
        #1;
        check("t6_async_valid", 32'(q.out_valid), 32'd0);
        check("t6_async_stop", 32'(q.in_stop), 32'd0);
        check("t6_async_count", 32'(q.count), 32'd0);
        q.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t6_after_release", 32'(q.out_valid), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
